bus_timer: RTL and testbench

Memory-mapped timer peripheral that sits on the responder side of the CPU data bus, alongside the DRAM and the other bridge-attached devices. It answers loads and stores issued from the CPU's MEM stage: reads return in the same cycle, and writes honour per-byte lane enables. Internally it runs a prescaled 32-bit up-counter with a compare match, optional auto-reload, a sticky status flag and a level interrupt output.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_timer_if.sv | 12 +
 rtl/bus_timer_core.sv | 41 ++++
 rtl/bus_timer.sv | 88 ++++++++
 tb/tb_bus_timer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the timer peripheral: register offsets, CTRL bit
// positions and the byte-lane merge used by every writable register.
package bus_pkg;

  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_PRESCALE = 3'd1;
  localparam logic [2:0] TMR_COUNT    = 3'd2;
  localparam logic [2:0] TMR_COMPARE  = 3'd3;
  localparam logic [2:0] TMR_STATUS   = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  we);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus responder signals for the timer; the CPU/bridge side is the
// master, the timer is the slave.
interface bus_timer_if;
  logic [31:0] Bus_addr;
  logic [3:0]  Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;
  logic        hit;

  modport master (output Bus_addr, Bus_we, Bus_wdata, input Bus_rdata, hit);
  modport slave  (input Bus_addr, Bus_we, Bus_wdata, output Bus_rdata, hit);
endinterface

// File: rtl/bus_timer_core.sv
// Prescaler, 32-bit up-counter and compare match. A bus write to COUNT
// overrides the tick update, but the compare always sees the old COUNT.
module timer_core #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             reload,
  input  logic [PRE_W-1:0] prescale,
  input  logic [31:0]      compare,
  input  logic             pre_clr,
  input  logic             count_wr,
  input  logic [31:0]      count_wdata,
  output logic [31:0]      count,
  output logic             match_set
);

  localparam logic [PRE_W-1:0] PRE_ONE = 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick      = en & (pre_cnt == prescale);
  assign match_set = tick & (count == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
    end else begin
      if (pre_clr || tick) pre_cnt <= '0;
      else if (en)         pre_cnt <= pre_cnt + PRE_ONE;

      if (count_wr)                 count <= count_wdata;
      else if (match_set && reload) count <= '0;
      else if (tick)                count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer: address decode, register file, lane merge and read
// mux around timer_core. Reads are combinational and side-effect free.
module bus_timer
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
  parameter int          PRE_W     = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  bus_timer_if.slave  bus,
  output logic        irq
);

  logic [2:0]       ctrl;
  logic [PRE_W-1:0] prescale;
  logic [31:0]      compare;
  logic [31:0]      count;
  logic             match;
  logic             match_set;

  logic [2:0]  off;
  logic        wr;
  logic        wr_ctrl, wr_pre, wr_count, wr_cmp, w1c;
  logic [31:0] reg_val;
  logic [31:0] merged;
  logic [1:0]  unused_addr_lsb;

  // The CPU does its own lane extraction, so the byte offset is irrelevant.
  assign unused_addr_lsb = bus.Bus_addr[1:0];

  assign bus.hit = (bus.Bus_addr[31:5] == BASE_ADDR[31:5]);
  assign off     = bus.Bus_addr[4:2];
  assign wr      = bus.hit & (|bus.Bus_we);

  assign wr_ctrl  = wr & (off == TMR_CTRL);
  assign wr_pre   = wr & (off == TMR_PRESCALE);
  assign wr_count = wr & (off == TMR_COUNT);
  assign wr_cmp   = wr & (off == TMR_COMPARE);
  assign w1c      = wr & (off == TMR_STATUS) & bus.Bus_we[0] & bus.Bus_wdata[0];

  always_comb begin
    reg_val = '0;
    case (off)
      TMR_CTRL:     reg_val = {29'd0, ctrl};
      TMR_PRESCALE: reg_val = 32'(prescale);
      TMR_COUNT:    reg_val = count;
      TMR_COMPARE:  reg_val = compare;
      TMR_STATUS:   reg_val = {31'd0, match};
      default:      reg_val = '0;
    endcase
  end

  // The same merged word feeds whichever register is addressed.
  assign merged        = merge(reg_val, bus.Bus_wdata, bus.Bus_we);
  assign bus.Bus_rdata = bus.hit ? reg_val : '0;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '1;
      match    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl     <= merged[2:0];
      if (wr_pre)  prescale <= merged[PRE_W-1:0];
      if (wr_cmp)  compare  <= merged;
      match <= match_set | (match & ~w1c);
      irq   <= match & ctrl[CTRL_IRQ_EN];
    end
  end

  timer_core #(.PRE_W(PRE_W)) u_core (
    .clk         (cpu_clk),
    .rst         (cpu_rst),
    .en          (ctrl[CTRL_EN]),
    .reload      (ctrl[CTRL_RELOAD]),
    .prescale    (prescale),
    .compare     (compare),
    .pre_clr     (wr_ctrl | wr_pre),
    .count_wr    (wr_count),
    .count_wdata (merged),
    .count       (count),
    .match_set   (match_set)
  );

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register access, counting, match/irq timing,
// lane writes and the edge cases around wrap, write/tick collision and reset.
module tb_bus_timer;

  localparam logic [31:0] BASE       = 32'hFFFF_F100;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
  localparam logic [31:0] A_COUNT    = BASE + 32'h08;
  localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS   = BASE + 32'h10;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  bus_timer_if bus ();

  bus_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    @(negedge cpu_clk);
    bus.Bus_addr  = addr;
    bus.Bus_we    = we;
    bus.Bus_wdata = data;
    @(posedge cpu_clk);
    #1;
    bus.Bus_we = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.Bus_we   = 4'b0000;
    bus.Bus_addr = addr;
    #1;
    data = bus.Bus_rdata;
  endtask

  // Samples COUNT, STATUS and irq in the low phase of the next clock.
  task automatic peek(output logic [31:0] cnt, output logic [31:0] st, output logic irq_o);
    @(negedge cpu_clk);
    bus_read(A_COUNT, cnt);
    bus_read(A_STATUS, st);
    irq_o = irq;
  endtask

  task automatic do_reset;
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    bus.Bus_we = 4'b0000;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] exp_val [5];
    logic [31:0] addr_tab [5];
    logic [31:0] hit_addr [5];
    logic        hit_exp [5];
    exp_val  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    addr_tab = '{A_CTRL, A_PRESCALE, A_COUNT, A_COMPARE, A_STATUS};
    hit_addr = '{BASE - 32'd4, BASE, BASE + 32'h1F, BASE + 32'h20, 32'h0000_F100};
    hit_exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      bus_read(addr_tab[i], d);
      checks++;
      if (d !== exp_val[i]) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h expected %h", i, d, exp_val[i]);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b expected 0", irq);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(hit_addr[i], d);
      checks++;
      if (bus.hit !== hit_exp[i]) begin
        errors++;
        $display("FAIL hit[%h] got %b expected %b", hit_addr[i], bus.hit, hit_exp[i]);
      end
    end
    bus_read(BASE + 32'h2C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL miss_rdata got %h expected 00000000", d);
    end
    bus_read(BASE + 32'h0E, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL addr_lsb_ignored got %h expected ffffffff", d);
    end
  endtask

  task automatic test_match_noreload;
    logic [31:0] c, s, es;
    logic        i;
    do_reset;
    bus_write(A_COMPARE, 4'hF, 32'd5);
    bus_write(A_PRESCALE, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h5);
    for (int k = 0; k < 8; k++) begin
      peek(c, s, i);
      es = (k >= 6) ? 32'd1 : 32'd0;
      checks++;
      if (c !== 32'(k)) begin
        errors++;
        $display("FAIL noreload_count[%0d] got %h expected %h", k, c, 32'(k));
      end
      checks++;
      if (s !== es) begin
        errors++;
        $display("FAIL noreload_match[%0d] got %h expected %h", k, s, es);
      end
      checks++;
      if (i !== (k >= 7)) begin
        errors++;
        $display("FAIL noreload_irq[%0d] got %b expected %b", k, i, (k >= 7));
      end
    end
    bus_write(A_STATUS, 4'h2, 32'hFFFF_FFFF);
    peek(c, s, i);
    checks++;
    if (s !== 32'd1) begin
      errors++;
      $display("FAIL w1c_lane1_only got %h expected 00000001", s);
    end
    bus_write(A_STATUS, 4'h1, 32'd1);
    peek(c, s, i);
    checks++;
    if (s !== 32'd0) begin
      errors++;
      $display("FAIL w1c_match got %h expected 00000000", s);
    end
    peek(c, s, i);
    checks++;
    if (i !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq got %b expected 0", i);
    end
  endtask

  task automatic test_match_reload;
    logic [31:0] c, s;
    logic        i;
    logic [31:0] exp_c [8];
    exp_c = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
    do_reset;
    bus_write(A_COMPARE, 4'hF, 32'd5);
    bus_write(A_PRESCALE, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h7);
    for (int k = 0; k < 8; k++) begin
      peek(c, s, i);
      checks++;
      if (c !== exp_c[k]) begin
        errors++;
        $display("FAIL reload_count[%0d] got %h expected %h", k, c, exp_c[k]);
      end
    end
    checks++;
    if (s !== 32'd1 || i !== 1'b1) begin
      errors++;
      $display("FAIL reload_match_irq got %h/%b expected 00000001/1", s, i);
    end
  endtask

  task automatic test_prescale;
    logic [31:0] c, s;
    logic        i;
    logic [31:0] exp_c [5];
    exp_c = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
    do_reset;
    bus_write(A_PRESCALE, 4'hF, 32'd3);
    bus_write(A_CTRL, 4'hF, 32'h1);
    for (int k = 0; k < 10; k++) begin
      peek(c, s, i);
      checks++;
      if (c !== 32'(k / 4)) begin
        errors++;
        $display("FAIL prescale_count[%0d] got %h expected %h", k, c, 32'(k / 4));
      end
    end
    bus_write(A_PRESCALE, 4'h3, 32'd3);
    for (int j = 0; j < 5; j++) begin
      peek(c, s, i);
      checks++;
      if (c !== exp_c[j]) begin
        errors++;
        $display("FAIL prescale_restart[%0d] got %h expected %h", j, c, exp_c[j]);
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d;
    do_reset;
    bus_write(A_COMPARE, 4'hF, 32'h0);
    bus_write(A_COMPARE, 4'b0100, 32'hAAAA_AAAA);
    bus_read(A_COMPARE, d);
    checks++;
    if (d !== 32'h00AA_0000) begin
      errors++;
      $display("FAIL lane_write got %h expected 00aa0000", d);
    end
    bus_write(A_COMPARE, 4'b0000, 32'hFFFF_FFFF);
    bus_read(A_COMPARE, d);
    checks++;
    if (d !== 32'h00AA_0000) begin
      errors++;
      $display("FAIL we_zero got %h expected 00aa0000", d);
    end
    bus_write(A_PRESCALE, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_PRESCALE, d);
    checks++;
    if (d !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL prescale_width got %h expected 0000ffff", d);
    end
    bus_write(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h14, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reserved_reg got %h expected 00000000", d);
    end
    bus_write(A_CTRL, 4'hF, 32'hFFFF_FFF8);
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_unused_bits got %h expected 00000000", d);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] c, s;
    logic        i;
    do_reset;
    bus_write(A_COUNT, 4'hF, 32'hFFFF_FFFF);
    bus_write(A_COMPARE, 4'hF, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h1);
    peek(c, s, i);
    checks++;
    if (c !== 32'hFFFF_FFFF || s !== 32'd0) begin
      errors++;
      $display("FAIL wrap_start got %h/%h expected ffffffff/00000000", c, s);
    end
    peek(c, s, i);
    checks++;
    if (c !== 32'h0 || s !== 32'd0) begin
      errors++;
      $display("FAIL wrap_zero got %h/%h expected 00000000/00000000", c, s);
    end
    peek(c, s, i);
    checks++;
    if (c !== 32'h1 || s !== 32'd1) begin
      errors++;
      $display("FAIL wrap_match got %h/%h expected 00000001/00000001", c, s);
    end
  endtask

  task automatic test_count_write_tick;
    logic [31:0] c, s;
    logic        i;
    do_reset;
    bus_write(A_COMPARE, 4'hF, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h1);
    bus_write(A_COUNT, 4'hF, 32'h1234_0000);
    peek(c, s, i);
    checks++;
    if (c !== 32'h1234_0000) begin
      errors++;
      $display("FAIL write_wins_count got %h expected 12340000", c);
    end
    checks++;
    if (s !== 32'd1) begin
      errors++;
      $display("FAIL write_old_compare got %h expected 00000001", s);
    end
    peek(c, s, i);
    checks++;
    if (c !== 32'h1234_0001) begin
      errors++;
      $display("FAIL write_then_count got %h expected 12340001", c);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] c, s, d;
    logic        i;
    do_reset;
    bus_write(A_COMPARE, 4'hF, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h5);
    peek(c, s, i);
    peek(c, s, i);
    peek(c, s, i);
    checks++;
    if (c !== 32'd2 || i !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state got %h/%b expected 00000002/1", c, i);
    end
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL async_irq got %b expected 0", irq);
    end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL async_ctrl got %h expected 00000000", d);
    end
    bus_read(A_COUNT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL async_count got %h expected 00000000", d);
    end
    bus_read(A_COMPARE, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL async_compare got %h expected ffffffff", d);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL async_status got %h expected 00000000", d);
    end
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  initial begin
    bus.Bus_addr  = 32'h0;
    bus.Bus_we    = 4'b0000;
    bus.Bus_wdata = 32'h0;
    test_reset;
    test_match_noreload;
    test_match_reload;
    test_prescale;
    test_byte_lanes;
    test_wrap;
    test_count_write_tick;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
